spram_wb_arbiter: RTL

Two-master Wishbone classic arbiter that shares one single-port synchronous RAM between two requesters, for example the J1 data port (m0) and a host/DMA port (m1). It sequences each transfer through the RAM's one-cycle read latency and returns acknowledge and read data to the granted master. Grants are fair round-robin. It drives the RAM's address, data, wren and cen pins directly.

---
 rtl/spram_wb_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/spram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spram_wb_arbiter
// Description : Two-master Wishbone classic arbiter that shares a single-port
//               synchronous RAM. Each transfer costs one request cycle and
//               one acknowledge cycle. Contention is resolved round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module spram_wb_arbiter #(
    parameter int size       = 'h1000,
    parameter int addr_width = $clog2(size),
    parameter int data_width = 16
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [addr_width-1:0] m0_adr_i,
    input  logic [data_width-1:0] m0_dat_i,
    output logic [data_width-1:0] m0_dat_o,
    output logic                  m0_ack_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [addr_width-1:0] m1_adr_i,
    input  logic [data_width-1:0] m1_dat_i,
    output logic [data_width-1:0] m1_dat_o,
    output logic                  m1_ack_o,

    output logic [addr_width-1:0] ram_address,
    output logic [data_width-1:0] ram_data,
    input  logic [data_width-1:0] ram_q,
    output logic                  ram_wren,
    output logic                  ram_cen
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q,  last_d;

    logic   w_req0;
    logic   w_req1;
    logic   w_any_req;
    logic   w_winner;
    logic   w_in_ack;

    assign w_req0    = m0_cyc_i & m0_stb_i;
    assign w_req1    = m1_cyc_i & m1_stb_i;
    assign w_any_req = w_req0 | w_req1;

    // A lone requester wins outright; on a tie the master not served last wins.
    assign w_winner  = (w_req0 & w_req1) ? ~last_q : w_req1;

    // Next-state decode: arbitrate in IDLE, spend exactly one cycle in ACK.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    state_d = ST_ACK;
                    grant_d = w_winner;
                    last_d  = w_winner;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; last resets to 1 so m0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // RAM pins: enabled only in the arbitration cycle; idle values follow m0
    // so the address/data buses never float to X.
    always_comb begin
        ram_address = m0_adr_i;
        ram_data    = m0_dat_i;
        ram_cen     = 1'b0;
        ram_wren    = 1'b0;
        if (!reset && (state_q == ST_IDLE) && w_any_req) begin
            ram_cen = 1'b1;
            if (w_winner) begin
                ram_address = m1_adr_i;
                ram_data    = m1_dat_i;
                ram_wren    = m1_we_i;
            end else begin
                ram_wren    = m0_we_i;
            end
        end
    end

    // Ack only the granted master, and only while it is still requesting.
    assign w_in_ack = !reset && (state_q == ST_ACK);
    assign m0_ack_o = w_in_ack & ~grant_q & w_req0;
    assign m1_ack_o = w_in_ack &  grant_q & w_req1;

    // RAM output is registered inside the RAM and lines up with the ack cycle.
    assign m0_dat_o = ram_q;
    assign m1_dat_o = ram_q;

endmodule
`default_nettype wire
